nvme_sq_fetch_cq_post_axi: RTL



---
 rtl/nvme_q_pkg.sv | 37 +++
 rtl/nvme_q_ptr.sv | 39 +++
 rtl/nvme_sq_fetch_cq_post_axi.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nvme_q_pkg.sv
// Shared definitions for the NVMe SQ fetch / CQ post AXI master.
// FSM encodings, queue entry sizes and completion entry field layout.
package nvme_q_pkg;

  localparam logic [1:0] RD_IDLE    = 2'd0;
  localparam logic [1:0] RD_AR      = 2'd1;
  localparam logic [1:0] RD_DATA    = 2'd2;
  localparam logic [1:0] RD_PRESENT = 2'd3;

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_AW   = 2'd1;
  localparam logic [1:0] WR_W    = 2'd2;
  localparam logic [1:0] WR_B    = 2'd3;

  localparam int unsigned SQE_BYTES = 64;
  localparam int unsigned CQE_BYTES = 16;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam int unsigned CQE_CID_LSB    = 0;
  localparam int unsigned CQE_PHASE_BIT  = 16;
  localparam int unsigned CQE_STATUS_LSB = 17;

  function automatic logic [31:0] cqe_dw3(
    input logic [14:0] status,
    input logic        ph,
    input logic [15:0] cid
  );
    logic [31:0] dw;
    dw = '0;
    dw[CQE_CID_LSB +: 16]    = cid;
    dw[CQE_PHASE_BIT]        = ph;
    dw[CQE_STATUS_LSB +: 15] = status;
    return dw;
  endfunction

endpackage

// File: rtl/nvme_q_ptr.sv
// Queue pointer pair: locally advanced pointer plus doorbell-written peer.
// Provides wrap, empty and full compares; out-of-range doorbells are dropped.
module nvme_q_ptr #(
  parameter logic [15:0] QDEPTH = 16'h0040
) (
  input  logic        clk_in,
  input  logic        resetb,
  input  logic        inc,
  input  logic        db_valid,
  input  logic [15:0] db,
  output logic [15:0] ptr,
  output logic [15:0] db_reg,
  output logic        empty,
  output logic        full,
  output logic        wrap,
  output logic        db_err
);

  logic [15:0] nxt;

  assign wrap   = (ptr == QDEPTH - 16'd1);
  assign nxt    = wrap ? 16'd0 : ptr + 16'd1;
  assign empty  = (ptr == db_reg);
  assign full   = (nxt == db_reg);
  assign db_err = db_valid && (db >= QDEPTH);

  always_ff @(posedge clk_in) begin
    if (!resetb) begin
      ptr    <= '0;
      db_reg <= '0;
    end else begin
      if (inc)
        ptr <= nxt;
      if (db_valid && !db_err)
        db_reg <= db;
    end
  end

endmodule

// File: rtl/nvme_sq_fetch_cq_post_axi.sv
// AXI4 master fetching 64-byte SQ entries and posting 16-byte CQ entries.
// Read and write paths are independent FSMs sharing only the error flag.
module nvme_sq_fetch_cq_post_axi
  import nvme_q_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter int          UNIQUE_ID_SZ = 3,
  parameter logic [31:0] SQ_BASE      = 32'ha010_2000,
  parameter logic [31:0] CQ_BASE      = 32'ha010_3000,
  parameter logic [15:0] QDEPTH       = 16'h0040,
  parameter logic [15:0] SQID         = 16'h0001
) (
  input  logic                    clk_in,
  input  logic                    resetb,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [UNIQUE_ID_SZ-1:0] m_arid,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic                    m_rlast,
  input  logic [1:0]              m_rresp,
  input  logic [UNIQUE_ID_SZ-1:0] m_rid,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [UNIQUE_ID_SZ-1:0] m_awid,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [3:0]              m_wstrb,
  output logic                    m_wlast,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [1:0]              m_bresp,
  input  logic [UNIQUE_ID_SZ-1:0] m_bid,
  input  logic [15:0]             sq_tail_db,
  input  logic                    sq_tail_db_valid,
  input  logic [15:0]             cq_head_db,
  input  logic                    cq_head_db_valid,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [511:0]            cmd_data,
  input  logic                    cpl_valid,
  output logic                    cpl_ready,
  input  logic [15:0]             cpl_cid,
  input  logic [14:0]             cpl_status,
  input  logic [31:0]             cpl_dw0,
  output logic [15:0]             sq_head,
  output logic [15:0]             cq_tail,
  output logic                    phase,
  output logic                    err
);

  logic [1:0]  rd_state;
  logic [3:0]  rd_beat;
  logic        rd_bad;
  logic [1:0]  wr_state;
  logic [1:0]  wr_beat;
  logic [31:0] lat_dw0;
  logic [15:0] lat_cid;
  logic [14:0] lat_status;
  logic [15:0] lat_sqh;

  logic        sq_empty;
  logic        sq_inc;
  logic        sq_db_err;
  logic        cq_full;
  logic        cq_inc;
  logic        cq_wrap;
  logic        cq_db_err;
  logic        rd_last;
  logic        rd_resp_bad;
  logic        rd_err;
  logic        b_err;
  logic        cpl_fire;

  logic [15:0] unused_sq_tail_reg;
  logic [15:0] unused_cq_head_reg;
  logic        unused_sq_full;
  logic        unused_sq_wrap;
  logic        unused_cq_empty;
  logic        unused_ids;

  assign unused_ids = ^{m_rid, m_bid};

  nvme_q_ptr #(.QDEPTH(QDEPTH)) u_sq (
    .clk_in   (clk_in),
    .resetb   (resetb),
    .inc      (sq_inc),
    .db_valid (sq_tail_db_valid),
    .db       (sq_tail_db),
    .ptr      (sq_head),
    .db_reg   (unused_sq_tail_reg),
    .empty    (sq_empty),
    .full     (unused_sq_full),
    .wrap     (unused_sq_wrap),
    .db_err   (sq_db_err)
  );

  nvme_q_ptr #(.QDEPTH(QDEPTH)) u_cq (
    .clk_in   (clk_in),
    .resetb   (resetb),
    .inc      (cq_inc),
    .db_valid (cq_head_db_valid),
    .db       (cq_head_db),
    .ptr      (cq_tail),
    .db_reg   (unused_cq_head_reg),
    .empty    (unused_cq_empty),
    .full     (cq_full),
    .wrap     (cq_wrap),
    .db_err   (cq_db_err)
  );

  assign m_arid   = '0;
  assign m_awid   = '0;
  assign m_arsize = 3'd2;
  assign m_awsize = 3'd2;
  assign m_wstrb  = 4'hF;
  assign m_arlen  = 8'd15;
  assign m_awlen  = 8'd3;

  assign m_araddr = ADDR_WIDTH'(SQ_BASE)
                  + ADDR_WIDTH'(32'(sq_head) * SQE_BYTES);
  assign m_awaddr = ADDR_WIDTH'(CQ_BASE)
                  + ADDR_WIDTH'(32'(cq_tail) * CQE_BYTES);

  assign m_arvalid = (rd_state == RD_AR);
  assign m_rready  = (rd_state == RD_DATA);
  assign cmd_valid = (rd_state == RD_PRESENT);

  assign rd_last     = (rd_beat == 4'hF);
  assign rd_resp_bad = (m_rresp != AXI_RESP_OKAY);
  assign rd_err      = m_rready && m_rvalid
                     && (rd_resp_bad || (m_rlast != rd_last));

  // A bad entry retires at its last beat instead of being presented.
  assign sq_inc = (cmd_valid && cmd_ready)
                || (m_rready && m_rvalid && rd_last
                    && (rd_bad || rd_resp_bad));

  always_ff @(posedge clk_in) begin
    if (!resetb) begin
      rd_state <= RD_IDLE;
      rd_beat  <= '0;
      rd_bad   <= 1'b0;
      cmd_data <= '0;
    end else begin
      unique case (rd_state)
        RD_IDLE:
          if (!sq_empty)
            rd_state <= RD_AR;
        RD_AR:
          if (m_arready) begin
            rd_state <= RD_DATA;
            rd_beat  <= '0;
            rd_bad   <= 1'b0;
          end
        RD_DATA:
          if (m_rvalid) begin
            cmd_data[32*rd_beat +: 32] <= m_rdata;
            rd_beat <= rd_beat + 4'd1;
            if (rd_resp_bad)
              rd_bad <= 1'b1;
            if (rd_last)
              rd_state <= (rd_bad || rd_resp_bad) ? RD_IDLE : RD_PRESENT;
          end
        RD_PRESENT:
          if (cmd_ready)
            rd_state <= RD_IDLE;
        default:
          rd_state <= RD_IDLE;
      endcase
    end
  end

  assign cpl_ready = (wr_state == WR_IDLE) && cpl_valid && !cq_full;
  assign cpl_fire  = cpl_ready;
  assign m_awvalid = (wr_state == WR_AW);
  assign m_wvalid  = (wr_state == WR_W);
  assign m_wlast   = (wr_state == WR_W) && (wr_beat == 2'd3);
  assign m_bready  = (wr_state == WR_B);
  assign b_err     = m_bready && m_bvalid && (m_bresp != AXI_RESP_OKAY);
  assign cq_inc    = m_bready && m_bvalid;

  always_comb begin
    m_wdata = '0;
    unique case (wr_beat)
      2'd0: m_wdata = lat_dw0;
      2'd1: m_wdata = '0;
      2'd2: m_wdata = {SQID, lat_sqh};
      2'd3: m_wdata = cqe_dw3(lat_status, phase, lat_cid);
      default: m_wdata = '0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!resetb) begin
      wr_state   <= WR_IDLE;
      wr_beat    <= '0;
      lat_dw0    <= '0;
      lat_cid    <= '0;
      lat_status <= '0;
      lat_sqh    <= '0;
    end else begin
      unique case (wr_state)
        WR_IDLE:
          if (cpl_fire) begin
            wr_state   <= WR_AW;
            lat_dw0    <= cpl_dw0;
            lat_cid    <= cpl_cid;
            lat_status <= cpl_status;
            lat_sqh    <= sq_head;
          end
        WR_AW:
          if (m_awready) begin
            wr_state <= WR_W;
            wr_beat  <= '0;
          end
        WR_W:
          if (m_wready) begin
            wr_beat <= wr_beat + 2'd1;
            if (wr_beat == 2'd3)
              wr_state <= WR_B;
          end
        WR_B:
          if (m_bvalid)
            wr_state <= WR_IDLE;
        default:
          wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!resetb) begin
      phase <= 1'b1;
      err   <= 1'b0;
    end else begin
      if (cq_inc && cq_wrap)
        phase <= ~phase;
      if (sq_db_err || cq_db_err || rd_err || b_err)
        err <= 1'b1;
    end
  end

endmodule
